alu_mul_ctrl: RTL
=================

# alu_mul_ctrl

Multi-cycle controller that computes a 16-bit product by sequencing the shared Hack-style ALU (zx/nx/zy/ny/f/no) through shift-and-add steps. It owns the ALU operand buses and control bits while busy and exposes a start/busy/done handshake to the CPU control path. The ALU itself stays outside this block: the controller drives x, y and the six control bits, and samples the ALU result combinationally in the same cycle. The result is the low 16 bits of a × b, which is correct for both unsigned and two's-complement operands.

## Interface
- No parameters; the data width is fixed at 16.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  16  multiplicand; latched when start is accepted.
- b  in  16  multiplier; latched when start is accepted.
- busy  out  1  high in ADD, DBL and DONE.
- done  out  1  one-cycle pulse in DONE.
- product  out  16  result register; loaded on entry to DONE, held until the next accepted start completes.
- alu_x  out  16  ALU x operand.
- alu_y  out  16  ALU y operand.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits.
- alu_out  in  16  ALU result, combinational from alu_x, alu_y and the control bits.

## Operation
- Internal registers:
  - acc (16), the running sum.
  - mcand (16), the shifted multiplicand.
  - mplr (16), the shifted multiplier.
  - state (2 bits).
- States are IDLE, ADD, DBL and DONE.
- IDLE:
  - busy=0, done=0.
  - ALU is driven with x=y=0 and the constant-zero code zx=1 nx=0 zy=1 ny=0 f=1 no=0.
  - On start=1: mcand<=a, mplr<=b, acc<=0, go to ADD.
- ADD:
  - Drive x=acc, y=mcand, add code zx=0 nx=0 zy=0 ny=0 f=1 no=0.
  - If mplr==0: go to DONE and load product<=acc; acc is not updated.
  - Else: if mplr[0]==1 then acc<=alu_out; go to DBL.
- DBL:
  - Drive x=mcand, y=mcand, add code.
  - mcand<=alu_out, which doubles mcand modulo 2^16.
  - mplr<=mplr>>1, with zero fill.
  - Go to ADD.
- DONE:
  - done=1, busy=1; ALU driven with the constant-zero code.
  - Go to IDLE.
- Arithmetic is modulo 2^16: carries out of the ALU adder are discarded and no overflow flag is produced.
- Termination is by mplr reaching zero. After 16 DBL steps mplr is guaranteed zero, so no bit counter is needed.
- start while busy (ADD, DBL or DONE) is ignored and not queued. a and b may change freely after acceptance.
- reset:
  - Next edge forces IDLE; acc, mcand, mplr and product are cleared; busy=0, done=0.
  - Applies mid-operation too; the aborted result is lost.
- Reset values: busy=0, done=0, product=0x0000, alu_x=alu_y=0x0000, ALU controls = constant-zero code.

## Timing
- start is sampled at edge E0, which is the transition IDLE→ADD; busy rises after E0.
- Let k be the index of the highest set bit of b.
  - The operation takes k+1 ADD/DBL pairs plus one terminating ADD.
  - done is high during cycle N after E0, where N = 2(k+1)+2.
  - b=0 gives N=2; the maximum is N=34 for b[15]=1.
- product is valid from the DONE cycle onward and stays stable until the next DONE.
- The earliest next start is the cycle after DONE (IDLE). Back-to-back throughput is N+1 cycles per operation.
- All ALU-facing outputs are decoded from state and registers only, not from start, so there is no combinational path from start to the ALU.

## Test plan
- a=3, b=5 (k=2): product=0x000F, done pulse exactly 8 cycles after start, busy high for cycles 1–8.
- a=0x1234, b=0: done at cycle 2, product=0x0000, exactly one ADD cycle observed on the ALU controls.
- a=0xFFFF, b=0xFFFF: done at cycle 34, product=0x0001; a=0xFFFD (−3), b=7: product=0xFFEB (−21), done at cycle 8.
- start pulsed again during ADD/DBL with different a and b: ignored, first result unchanged. start asserted in the cycle after DONE: accepted.
- reset asserted at cycle 5 of a=3, b=0x8000: next cycle busy=0, done=0, product=0, ALU controls are the constant-zero code. No done pulse follows.
- In every cycle, check the ALU bus against the state: IDLE/DONE show zero code with x=y=0; ADD shows x=acc, y=mcand; DBL shows x=y=mcand.

Source files
------------

// File: rtl/alu_mul_ctrl_if.sv
// CPU-side handshake and shared-ALU bus of the shift-and-add multiply controller.
// The slave modport is the controller's view; the master side is the CPU plus the ALU.
interface alu_mul_ctrl_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx;
    logic        alu_nx;
    logic        alu_zy;
    logic        alu_ny;
    logic        alu_f;
    logic        alu_no;
    logic [15:0] alu_out;

    modport slave (
        input  start, a, b, alu_out,
        output busy, done, product,
               alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
    );

    modport master (
        output start, a, b, alu_out,
        input  busy, done, product,
               alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
    );
endinterface

// File: rtl/alu_mul_ctrl.sv
// 16-bit shift-and-add multiplier that borrows the shared Hack-style ALU for every addition.
// Yields the low 16 bits of a*b; it stops as soon as the shifted multiplier reaches zero.
//
//   state | meaning
//   IDLE  | ALU parked on constant zero, waiting for start
//   ADD   | acc + mcand on the ALU; latch into acc if mplr[0], finish if mplr == 0
//   DBL   | mcand + mcand on the ALU; mplr shifts right
//   DONE  | one-cycle done pulse, product valid
module alu_mul_ctrl (
    input  logic          clk_i,
    input  logic          reset_i,
    alu_mul_ctrl_if.slave bus_if
);
    typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} state_t;

    // {zx, nx, zy, ny, f, no}
    localparam logic [5:0] CTRL_ZERO = 6'b101010;
    localparam logic [5:0] CTRL_ADD  = 6'b000010;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplr_q, mplr_d;
    logic [15:0] product_q, product_d;

    logic        busy, done;
    logic [15:0] alu_x, alu_y;
    logic [5:0]  ctrl;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            product_q <= product_d;
        end
    end

    // ALU-facing outputs depend only on state and registers, never on start.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;
        alu_x     = '0;
        alu_y     = '0;
        ctrl      = CTRL_ZERO;
        case (state_q)
            IDLE: begin
                if (bus_if.start) begin
                    mcand_d = bus_if.a;
                    mplr_d  = bus_if.b;
                    acc_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                busy  = 1'b1;
                alu_x = acc_q;
                alu_y = mcand_q;
                ctrl  = CTRL_ADD;
                if (mplr_q == '0) begin
                    product_d = acc_q;
                    state_d   = DONE;
                end else begin
                    if (mplr_q[0]) begin
                        acc_d = bus_if.alu_out;
                    end
                    state_d = DBL;
                end
            end
            DBL: begin
                busy    = 1'b1;
                alu_x   = mcand_q;
                alu_y   = mcand_q;
                ctrl    = CTRL_ADD;
                mcand_d = bus_if.alu_out;
                mplr_d  = {1'b0, mplr_q[15:1]};
                state_d = ADD;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_if.busy    = busy;
    assign bus_if.done    = done;
    assign bus_if.product = product_q;
    assign bus_if.alu_x   = alu_x;
    assign bus_if.alu_y   = alu_y;
    assign {bus_if.alu_zx, bus_if.alu_nx, bus_if.alu_zy,
            bus_if.alu_ny, bus_if.alu_f,  bus_if.alu_no} = ctrl;
endmodule
